// File: rtl/crc_serial_param_if.sv
// Serial CRC engine handshake bundle.
// Framer-side controls and line-side results in one interface.
interface crc_serial_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             check;
    logic             din;
    logic             din_valid;
    logic             din_last;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic [WIDTH-1:0] crc_value;

    modport master (
        output start,
        output check,
        output din,
        output din_valid,
        output din_last,
        input  dout,
        input  dout_valid,
        input  busy,
        input  done,
        input  crc_ok,
        input  crc_value
    );

    modport slave (
        input  start,
        input  check,
        input  din,
        input  din_valid,
        input  din_last,
        output dout,
        output dout_valid,
        output busy,
        output done,
        output crc_ok,
        output crc_value
    );
endinterface

// File: rtl/crc_serial_param.sv
// Parametrised bit-serial CRC engine, MSB-first, no reflection.
// Passes data through, then appends (generate) or verifies (check) the CRC.
module crc_serial_param #(
    parameter int          WIDTH  = 32,
    parameter logic [63:0] POLY   = 64'h0000_0000_04C1_1DB7,
    parameter logic [63:0] INIT   = '1,
    parameter logic [63:0] XOROUT = '1
) (
    input logic               clk,
    input logic               rst,
    crc_serial_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] POLY_W = POLY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_W = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] XOR_W  = XOROUT[WIDTH-1:0];
    localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        EMIT,
        RECV
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [WIDTH-1:0] fin_q, fin_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic             dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [WIDTH-1:0] val_q, val_d;

    logic             fb;
    logic [WIDTH-1:0] crc_step;
    logic [WIDTH-1:0] fin_next;
    logic             miss;

    // One-bit CRC advance on the incoming data bit.
    always_comb begin
        fb       = crc_q[WIDTH-1] ^ bus.din;
        crc_step = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY_W : '0);
        fin_next = crc_step ^ XOR_W;
    end

    // Frame sequencing, passthrough, emission and trailer comparison.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        fin_d   = fin_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;
        dout_d  = 1'b0;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        ok_d    = ok_q;
        val_d   = val_q;
        miss    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    crc_d   = INIT_W;
                    mode_d  = bus.check;
                    ok_d    = 1'b0;
                    val_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.din_valid) begin
                    crc_d  = crc_step;
                    dout_d = bus.din;
                    dv_d   = 1'b1;
                    if (bus.din_last) begin
                        fin_d   = fin_next;
                        sh_d    = fin_next;
                        cnt_d   = '0;
                        state_d = mode_q ? RECV : EMIT;
                    end
                end
            end
            EMIT: begin
                dout_d = sh_q[WIDTH-1];
                dv_d   = 1'b1;
                sh_d   = {sh_q[WIDTH-2:0], 1'b0};
                if (cnt_q == LAST) begin
                    done_d  = 1'b1;
                    val_d   = fin_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RECV: begin
                if (bus.din_valid) begin
                    miss  = bus.din ^ sh_q[WIDTH-1];
                    err_d = err_q | miss;
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == LAST) begin
                        done_d  = 1'b1;
                        ok_d    = ~(err_q | miss);
                        val_d   = fin_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= '0;
            fin_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            fin_q   <= fin_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            val_q   <= val_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.crc_ok     = ok_q;
    assign bus.crc_value  = val_q;
endmodule

// File: tb/tb_crc_serial_param.sv
// Bench for crc_serial_param: three configurations checked against
// a bit-list CRC model and an expected output-stream queue.
module tb_crc_serial_param;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    localparam int          WD [3] = '{32, 16, 16};
    localparam logic [63:0] PL [3] = '{64'h04C11DB7, 64'h1021, 64'h8005};
    localparam logic [63:0] IV [3] = '{64'hFFFFFFFF, 64'hFFFF, 64'h0};
    localparam logic [63:0] XV [3] = '{64'hFFFFFFFF, 64'h0, 64'h0};

    logic st [3];
    logic ck [3];
    logic di [3];
    logic dvi [3];
    logic dl [3];

    logic        dout_w [3];
    logic        dv_w [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        ok_w [3];
    logic [63:0] val_w [3];

    crc_serial_param_if #(.WIDTH(32)) if0 ();
    crc_serial_param_if #(.WIDTH(16)) if1 ();
    crc_serial_param_if #(.WIDTH(16)) if2 ();

    crc_serial_param #(
        .WIDTH(32)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(if0.slave)
    );

    crc_serial_param #(
        .WIDTH(16),
        .POLY(64'h1021),
        .INIT(64'hFFFF),
        .XOROUT(64'h0)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(if1.slave)
    );

    crc_serial_param #(
        .WIDTH(16),
        .POLY(64'h8005),
        .INIT(64'h0),
        .XOROUT(64'h0)
    ) dut2 (
        .clk(clk),
        .rst(rst),
        .bus(if2.slave)
    );

    assign if0.start     = st[0];
    assign if0.check     = ck[0];
    assign if0.din       = di[0];
    assign if0.din_valid = dvi[0];
    assign if0.din_last  = dl[0];
    assign if1.start     = st[1];
    assign if1.check     = ck[1];
    assign if1.din       = di[1];
    assign if1.din_valid = dvi[1];
    assign if1.din_last  = dl[1];
    assign if2.start     = st[2];
    assign if2.check     = ck[2];
    assign if2.din       = di[2];
    assign if2.din_valid = dvi[2];
    assign if2.din_last  = dl[2];

    assign dout_w[0] = if0.dout;
    assign dv_w[0]   = if0.dout_valid;
    assign busy_w[0] = if0.busy;
    assign done_w[0] = if0.done;
    assign ok_w[0]   = if0.crc_ok;
    assign val_w[0]  = {32'h0, if0.crc_value};
    assign dout_w[1] = if1.dout;
    assign dv_w[1]   = if1.dout_valid;
    assign busy_w[1] = if1.busy;
    assign done_w[1] = if1.done;
    assign ok_w[1]   = if1.crc_ok;
    assign val_w[1]  = {48'h0, if1.crc_value};
    assign dout_w[2] = if2.dout;
    assign dv_w[2]   = if2.dout_valid;
    assign busy_w[2] = if2.busy;
    assign done_w[2] = if2.done;
    assign ok_w[2]   = if2.crc_ok;
    assign val_w[2]  = {48'h0, if2.crc_value};

    int          n_chk = 0;
    int          n_fail = 0;
    int          act = 0;
    bit          mon_en = 0;
    bit          expq[$];
    int          ndata = 0;
    bit          exp_gen = 0;
    logic [63:0] exp_val = '0;
    bit          exp_ok = 0;
    int          done_cnt = 0;
    int          dv_cnt = 0;
    bit          dbits[$];
    bit          tbits[$];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference CRC over the data bit list, straight from the update rule.
    function automatic logic [63:0] crc_model(input int inst);
        int          w;
        logic [63:0] m;
        logic [63:0] r;
        bit          fb;
        w = WD[inst];
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r = IV[inst] & m;
        foreach (dbits[i]) begin
            fb = r[w-1] ^ dbits[i];
            r  = (r << 1) & m;
            if (fb) r = r ^ (PL[inst] & m);
        end
        return r ^ (XV[inst] & m);
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) dbits.push_back(b[k]);
    endtask

    task automatic load_123456789();
        dbits.delete();
        for (int k = 1; k <= 9; k++) push_byte(8'h30 + 8'(k));
    endtask

    task automatic set_tail(input logic [63:0] v, input int w);
        tbits.delete();
        for (int k = w - 1; k >= 0; k--) tbits.push_back(v[k]);
    endtask

    task automatic drv(input int inst, input logic s, input logic c,
                       input logic d, input logic v, input logic l);
        @(posedge clk);
        #1;
        st[inst]  = s;
        ck[inst]  = c;
        di[inst]  = d;
        dvi[inst] = v;
        dl[inst]  = l;
    endtask

    // Output-stream checker for the active instance.
    always @(negedge clk) begin
        bit b;
        if (mon_en && !rst) begin
            if (dv_w[act]) begin
                dv_cnt++;
                if (expq.size() == 0) begin
                    chk("extra_dout", dv_w[act], 0);
                end else begin
                    b = expq.pop_front();
                    chk("dout", dout_w[act], b);
                    if (ndata > 0) ndata--;
                    if (exp_gen && expq.size() == 0)
                        chk("done_with_last", done_w[act], 1);
                end
            end else if (exp_gen && ndata == 0 && expq.size() > 0) begin
                chk("emit_gap", dv_w[act], 1);
            end
            if (done_w[act]) begin
                done_cnt++;
                chk("busy_at_done", busy_w[act], 0);
                chk("done_early", expq.size(), 0);
                chk("val_at_done", val_w[act], exp_val);
                chk("ok_at_done", ok_w[act], exp_ok);
            end
        end
    end

    task automatic run_frame(input int inst, input bit cm, input int gap,
                             input bit noise, input int rst_at);
        int          w;
        int          nd;
        int          k;
        logic [63:0] fin;
        bit          okx;
        w   = WD[inst];
        nd  = dbits.size();
        fin = crc_model(inst);
        okx = 0;
        if (cm) begin
            okx = 1;
            for (int j = 0; j < w; j++)
                if (tbits[j] != fin[w-1-j]) okx = 0;
        end
        act = inst;
        expq.delete();
        foreach (dbits[i]) expq.push_back(dbits[i]);
        if (!cm) for (int j = w - 1; j >= 0; j--) expq.push_back(fin[j]);
        ndata    = nd;
        exp_gen  = !cm;
        exp_val  = fin;
        exp_ok   = okx;
        done_cnt = 0;
        dv_cnt   = 0;
        mon_en   = 1;
        if (noise)
            repeat (2) drv(inst, 0, 0, 1'($urandom), 1, 0);
        drv(inst, 1, cm, 1'($urandom), noise, 0);
        drv(inst, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("busy_start", busy_w[inst], 1);
        chk("val_cleared", val_w[inst], 0);
        chk("ok_cleared", ok_w[inst], 0);
        for (int i = 0; i < nd; i++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap)
                drv(inst, 0, 0, 1'($urandom), 0, 1'($urandom));
            if (noise && i == nd / 2)
                drv(inst, 1, !cm, 1'($urandom), 0, 0);
            drv(inst, 0, 0, dbits[i], 1, i == nd - 1);
        end
        if (cm) begin
            for (int j = 0; j < w; j++) begin
                while (gap > 0 && $urandom_range(0, 99) < gap)
                    drv(inst, 0, 0, 1'($urandom), 0, 1'($urandom));
                drv(inst, 0, 0, tbits[j], 1, 1'($urandom));
            end
            drv(inst, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("done_recv", done_w[inst], 1);
        end else begin
            for (int j = 0; j < w + 20; j++) begin
                drv(inst, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom));
                @(negedge clk);
                #1;
                if (rst_at >= 0 && ndata == 0 && (w - expq.size()) == rst_at) begin
                    mon_en = 0;
                    rst    = 1;
                    drv(inst, 0, 0, 0, 0, 0);
                    rst = 0;
                    @(negedge clk);
                    chk("rst_busy", busy_w[inst], 0);
                    chk("rst_dv", dv_w[inst], 0);
                    chk("rst_val", val_w[inst], 0);
                    repeat (3) begin
                        chk("rst_no_done", done_w[inst], 0);
                        chk("rst_dv_idle", dv_w[inst], 0);
                        @(negedge clk);
                    end
                    expq.delete();
                    return;
                end
                if (done_cnt > 0) break;
            end
        end
        k = 0;
        while (done_cnt == 0 && k < 50) begin
            drv(inst, 0, 0, 0, 0, 0);
            @(negedge clk);
            #1;
            k++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        repeat (3) drv(inst, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("done_count", done_cnt, 1);
        chk("busy_end", busy_w[inst], 0);
        chk("val_hold", val_w[inst], exp_val);
        chk("ok_hold", ok_w[inst], exp_ok);
        chk("dv_total", dv_cnt, nd + (cm ? 0 : w));
        chk("queue_drained", expq.size(), 0);
        mon_en = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        int          inst;
        int          len;
        bit          cm;
        for (int i = 0; i < 3; i++) begin
            st[i]  = 0;
            ck[i]  = 0;
            di[i]  = 0;
            dvi[i] = 0;
            dl[i]  = 0;
        end
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_busy", busy_w[i], 0);
            chk("reset_dv", dv_w[i], 0);
            chk("reset_done", done_w[i], 0);
            chk("reset_ok", ok_w[i], 0);
            chk("reset_val", val_w[i], 0);
        end
        #1 rst = 0;

        load_123456789();
        chk("model_crc32_bzip2", crc_model(0), 64'hFC891918);
        chk("model_ccitt_false", crc_model(1), 64'h29B1);
        chk("model_buypass", crc_model(2), 64'hFEE8);

        run_frame(0, 0, 0, 0, -1);
        chk("t1_value", val_w[0], 64'hFC891918);
        chk("t1_dv_104", dv_cnt, 104);

        run_frame(1, 0, 0, 0, -1);
        v = val_w[1];
        run_frame(1, 0, 40, 0, -1);
        chk("t2_contig", v, 64'h29B1);
        chk("t2_gapped", val_w[1], 64'h29B1);

        set_tail(64'hFEE8, 16);
        run_frame(2, 1, 25, 0, -1);
        chk("t3_ok_pass", ok_w[2], 1);
        chk("t3_val", val_w[2], 64'hFEE8);
        set_tail(64'hFEE9, 16);
        run_frame(2, 1, 25, 0, -1);
        chk("t3_ok_fail", ok_w[2], 0);

        run_frame(0, 0, 0, 0, 10);
        dbits.delete();
        push_byte(8'h00);
        run_frame(0, 0, 0, 0, -1);
        chk("t4_after_reset", val_w[0], crc_model(0));

        load_123456789();
        run_frame(0, 0, 30, 1, -1);
        chk("t5_noise", val_w[0], 64'hFC891918);

        dbits.delete();
        dbits.push_back(1'b1);
        run_frame(0, 0, 0, 0, -1);
        chk("t6_single", val_w[0], crc_model(0));

        for (int n = 0; n < 14; n++) begin
            inst = $urandom_range(0, 2);
            len  = $urandom_range(1, 40);
            cm   = 1'($urandom);
            dbits.delete();
            repeat (len) dbits.push_back(1'($urandom));
            v = crc_model(inst);
            if ($urandom_range(0, 1) == 1)
                v[$urandom_range(0, WD[inst] - 1)] ^= 1'b1;
            set_tail(v, WD[inst]);
            run_frame(inst, cm, $urandom_range(0, 50), 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
